// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the load/store unit: RV32 funct3 width
//            codes, FSM state encoding and the default bus timeout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   // RV32 load/store width codes carried in funct3
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Maximum REQ cycles without bus_ready before the access is aborted
   localparam int TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_if
// Purpose  : Ready/valid data bus between the load/store unit and memory.
// Ports    : bus_valid/bus_we/bus_addr/bus_be/bus_wdata driven by the master;
//            bus_ready/bus_rdata/bus_err driven by the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_bus_if;

   logic        bus_valid;
   logic        bus_ready;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_err;

   modport master (
      output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ready, bus_rdata, bus_err
   );

   modport slave (
      input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ready, bus_rdata, bus_err
   );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational data alignment for the load/store unit.
//            Request side: byte enables, store data replication and
//            misalignment / illegal-width detection.
//            Load side: shift the read word down and sign/zero extend.
// Ports    : req_funct3, req_addr_lo, req_wdata -> be, wdata_rep, fault
//            ld_funct3, ld_addr_lo, rdata       -> ld_data
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  req_funct3,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic        fault,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [31:0] w_shift;

   always_comb begin
      be        = 4'b0000;
      wdata_rep = req_wdata;
      fault     = 1'b0;
      case (req_funct3)
         F3_B, F3_BU: begin
            be        = 4'b0001 << req_addr_lo;
            wdata_rep = {4{req_wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            be        = 4'b0011 << {req_addr_lo[1], 1'b0};
            wdata_rep = {2{req_wdata[15:0]}};
            fault     = req_addr_lo[0];
         end
         F3_W: begin
            be        = 4'b1111;
            fault     = |req_addr_lo;
         end
         default: fault = 1'b1;
      endcase
   end

   // Selected byte/half lands in the low bits before extension
   assign w_shift = rdata >> {ld_addr_lo, 3'b000};

   always_comb begin
      ld_data = w_shift;
      case (ld_funct3)
         F3_B:    ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
         F3_BU:   ld_data = {24'd0, w_shift[7:0]};
         F3_H:    ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
         F3_HU:   ld_data = {16'd0, w_shift[15:0]};
         default: ld_data = w_shift;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_bus.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus
// Purpose  : Load/store unit bridging the rv32 memory-access stage to a
//            ready/valid data bus with wait states. One access-stage op
//            becomes one bus transaction; the pipeline is stalled until it
//            completes. Misaligned/illegal ops fault without touching the
//            bus; bus errors and timeouts are reported on err.
// Ports    : clk, rst (async, active-low)
//            req_valid/req_we/req_funct3/req_addr/req_wdata - access request
//            stall, rsp_valid, rsp_rdata, fault, err        - pipeline side
//            bus (lsu_bus_if.master)                        - data bus
// Revision : 1.0 - initial release
// ============================================================================
module lsu_bus
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        fault,
   output logic        err,
   lsu_bus_if.master   bus
);

   localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

   lsu_state_t  r_state, w_state_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [2:0]  r_funct3;
   logic [31:0] r_rdata;
   logic        r_err;

   logic [3:0]  w_be;
   logic [31:0] w_wdata_rep;
   logic        w_fault;
   logic [31:0] w_ld_data;
   logic        w_idle_req;
   logic        w_issue;
   logic        w_reject;
   logic        w_done;
   logic        w_tmo;

   lsu_align u_align (
      .req_funct3  (req_funct3),
      .req_addr_lo (req_addr[1:0]),
      .req_wdata   (req_wdata),
      .be          (w_be),
      .wdata_rep   (w_wdata_rep),
      .fault       (w_fault),
      .ld_funct3   (r_funct3),
      .ld_addr_lo  (r_addr[1:0]),
      .rdata       (bus.bus_rdata),
      .ld_data     (w_ld_data)
   );

   // The IDLE-cycle responses are combinational on req_valid, so they are
   // also gated by rst to keep every output low while reset is asserted.
   assign w_idle_req = rst && (r_state == ST_IDLE) && req_valid;
   assign w_issue    = w_idle_req && !w_fault;
   assign w_reject   = w_idle_req &&  w_fault;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done      = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = 8'd0;
            if (w_issue) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.bus_ready) begin
               w_done      = 1'b1;
               w_state_nxt = ST_DONE;
            end else if (r_cnt == C_CNT_LAST) begin
               w_tmo       = 1'b1;
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt   = r_cnt + 8'd1;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we     <= 1'b0;
         r_addr   <= 32'd0;
         r_be     <= 4'd0;
         r_wdata  <= 32'd0;
         r_funct3 <= 3'd0;
         r_rdata  <= 32'd0;
         r_err    <= 1'b0;
      end else begin
         if (w_issue) begin
            r_we     <= req_we;
            r_addr   <= req_addr;
            r_be     <= w_be;
            r_wdata  <= w_wdata_rep;
            r_funct3 <= req_funct3;
         end
         if (w_done) begin
            r_rdata <= (r_we || bus.bus_err) ? 32'd0 : w_ld_data;
            r_err   <= bus.bus_err;
         end else if (w_tmo) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
         end
      end
   end

   assign stall     = w_issue || (r_state == ST_REQ);
   assign rsp_valid = w_reject || (r_state == ST_DONE);
   assign rsp_rdata = (r_state == ST_DONE) ? r_rdata : 32'd0;
   assign fault     = w_reject;
   assign err       = (r_state == ST_DONE) && r_err;

   assign bus.bus_valid = (r_state == ST_REQ);
   assign bus.bus_we    = (r_state == ST_REQ) && r_we;
   assign bus.bus_addr  = (r_state == ST_REQ) ? {r_addr[31:2], 2'b00} : 32'd0;
   assign bus.bus_be    = (r_state == ST_REQ) ? r_be : 4'd0;
   assign bus.bus_wdata = (r_state == ST_REQ) ? r_wdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_bus
// Purpose  : Directed self-checking bench for lsu_bus (TIMEOUT = 4).
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_bus;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        fault;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   lsu_bus_if bus_if ();

   lsu_bus #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .fault      (fault),
      .err        (err),
      .bus        (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Runs one legal access starting at posedge+1 in IDLE; returns at
   // posedge+1 back in IDLE.
   task automatic access(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input int waits,
                         input logic [31:0] brd, input logic berr, input logic [3:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] erd, input logic eerr);
      int n_stall;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      bus_if.bus_ready = 1'b0; bus_if.bus_err = 1'b0;
      #1;
      chk({tag, "_idle_stall"}, stall, 1'b1);
      chk({tag, "_idle_bvalid"}, bus_if.bus_valid, 1'b0);
      n_stall = 1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      bus_if.bus_err = 1'b1;          // must be ignored without ready
      bus_if.bus_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < waits; i++) begin
         #1;
         chk({tag, "_wait_bvalid"}, bus_if.bus_valid, 1'b1);
         chk({tag, "_wait_be"}, bus_if.bus_be, ebe);
         chk({tag, "_wait_wdata"}, bus_if.bus_wdata, ewd);
         if (stall) n_stall++;
         @(posedge clk); #1;
      end
      bus_if.bus_ready = 1'b1; bus_if.bus_rdata = brd; bus_if.bus_err = berr;
      #1;
      chk({tag, "_bvalid"}, bus_if.bus_valid, 1'b1);
      chk({tag, "_baddr"}, bus_if.bus_addr, {addr[31:2], 2'b00});
      chk({tag, "_be"}, bus_if.bus_be, ebe);
      chk({tag, "_we"}, bus_if.bus_we, we);
      chk({tag, "_wdata"}, bus_if.bus_wdata, ewd);
      chk({tag, "_rsp_early"}, rsp_valid, 1'b0);
      if (stall) n_stall++;
      @(posedge clk); #1;
      bus_if.bus_ready = 1'b0; bus_if.bus_err = 1'b0;
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
      chk({tag, "_rdata"}, rsp_rdata, erd);
      chk({tag, "_err"}, err, eerr);
      chk({tag, "_done_stall"}, stall, 1'b0);
      chk({tag, "_done_bvalid"}, bus_if.bus_valid, 1'b0);
      chk({tag, "_stall_cycles"}, n_stall, 2 + waits);
      @(posedge clk); #1;
      chk({tag, "_rsp_pulse"}, rsp_valid, 1'b0);
   endtask

   task automatic reject(input string tag, input logic [2:0] f3, input logic [31:0] addr);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = addr;
      #1;
      chk({tag, "_fault"}, fault, 1'b1);
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
      chk({tag, "_rdata"}, rsp_rdata, 32'd0);
      chk({tag, "_stall"}, stall, 1'b0);
      chk({tag, "_bvalid"}, bus_if.bus_valid, 1'b0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      #1;
      chk({tag, "_bvalid_after"}, bus_if.bus_valid, 1'b0);
      chk({tag, "_fault_pulse"}, fault, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
      req_addr = 32'h100; req_wdata = 32'h5555_5555;
      bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'd0; bus_if.bus_err = 1'b0;
      #2;
      chk("rst_stall", stall, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_fault", fault, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_bvalid", bus_if.bus_valid, 1'b0);
      chk("rst_bwe", bus_if.bus_we, 1'b0);
      chk("rst_baddr", bus_if.bus_addr, 32'd0);
      chk("rst_bbe", bus_if.bus_be, 4'd0);
      chk("rst_bwdata", bus_if.bus_wdata, 32'd0);
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      access("sw",   1'b1, F3_W,  32'h100, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0);
      access("lb",   1'b0, F3_B,  32'h103, 32'h0,         0, 32'h80FF_0000, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0);
      access("lbu",  1'b0, F3_BU, 32'h103, 32'h0,         0, 32'h80FF_0000, 1'b0, 4'b1000, 32'h0,         32'h0000_0080, 1'b0);
      access("sh",   1'b1, F3_H,  32'h102, 32'h1234_ABCD, 3, 32'h0,         1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0,         1'b0);
      access("sb",   1'b1, F3_B,  32'h101, 32'h1234_5678, 1, 32'h0,         1'b0, 4'b0010, 32'h7878_7878, 32'h0,         1'b0);
      access("lh",   1'b0, F3_H,  32'h100, 32'h0,         0, 32'h0000_F00D, 1'b0, 4'b0011, 32'h0,         32'hFFFF_F00D, 1'b0);
      access("lwerr",1'b0, F3_W,  32'h104, 32'h0,         0, 32'h1234_5678, 1'b1, 4'b1111, 32'h0,         32'h0,         1'b1);
      access("lw",   1'b0, F3_W,  32'h108, 32'h0,         2, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0);

      reject("mis_lw", F3_W, 32'h101);
      reject("ill_f3", 3'b011, 32'h100);
      reject("mis_lh", F3_HU, 32'h103);

      // Timeout: bus never answers
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h200;
      bus_if.bus_ready = 1'b0;
      #1;
      chk("tmo_idle_stall", stall, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("tmo_bvalid", bus_if.bus_valid, 1'b1);
         @(posedge clk); #1;
      end
      chk("tmo_bvalid_drop", bus_if.bus_valid, 1'b0);
      chk("tmo_rsp_valid", rsp_valid, 1'b1);
      chk("tmo_err", err, 1'b1);
      chk("tmo_rdata", rsp_rdata, 32'd0);
      chk("tmo_stall", stall, 1'b0);
      @(posedge clk); #1;
      chk("tmo_err_pulse", err, 1'b0);

      // Reset in the middle of a transaction
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h300;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #1;
      chk("mid_bvalid", bus_if.bus_valid, 1'b1);
      rst = 1'b0;
      #1;
      chk("mid_rst_bvalid", bus_if.bus_valid, 1'b0);
      chk("mid_rst_stall", stall, 1'b0);
      chk("mid_rst_rsp", rsp_valid, 1'b0);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_rsp", rsp_valid, 1'b0);
      chk("post_rst_err", err, 1'b0);
      chk("post_rst_bvalid", bus_if.bus_valid, 1'b0);

      access("lhu",  1'b0, F3_HU, 32'h002, 32'h0,         0, 32'h8001_1234, 1'b0, 4'b1100, 32'h0,         32'h0000_8001, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
